// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words from a valid/ready
// byte stream, writes them to instruction memory and holds the core until the load completes.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [31:0]           mem_write_data,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            index_q, index_d;
  logic [7:0]            word_count_q, word_count_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  release_q, release_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;
  logic [31:0]           shifted_word;

  // byte_ready is the only unregistered output and depends on the current state alone.
  assign byte_ready   = (state_q == S_HEADER) || (state_q == S_LOAD);
  assign accept       = byte_valid && byte_ready;
  assign shifted_word = {word_q[23:0], byte_data};

  // NOTE: every variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    index_d      = index_q;
    word_count_d = word_count_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (accept) begin
          if ((byte_data == 8'd0) || (32'(byte_data) > MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            len_d        = byte_data;
            index_d      = 8'd0;
            word_count_d = 8'd0;
            word_d       = 32'd0;
            byte_cnt_d   = 2'd0;
            state_d      = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          word_d     = shifted_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_addr_d = {index_q[ADDR_WIDTH-3:0], 2'b00};
            wr_data_d = shifted_word;
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        index_d      = index_q + 8'd1;
        word_count_d = word_count_q + 8'd1;
        word_d       = 32'd0;
        state_d      = ((index_q + 8'd1) == len_q) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with the state register.
    wr_en_d   = (state_d == S_WRITE);
    release_d = (state_d == S_DONE);
    busy_d    = (state_d == S_HEADER) || (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= 8'd0;
      index_q      <= 8'd0;
      word_count_q <= 8'd0;
      word_q       <= 32'd0;
      byte_cnt_q   <= 2'd0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      wr_en_q      <= 1'b0;
      release_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      index_q      <= index_d;
      word_count_q <= word_count_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      release_q    <= release_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign mem_write_enable  = wr_en_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign pc_enable         = release_q;
  assign if_id_enable      = release_q;
  assign core_reset        = !release_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign word_count        = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued by the stimulus
// and checked by an independent monitor whenever the write strobe is seen.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [7:0]  mem_write_address;
  logic [31:0] mem_write_data;
  logic        pc_enable, if_id_enable, core_reset, busy, done, error;
  logic [7:0]  word_count;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  prev_we = 1'b0;

  program_loader #(.ADDR_WIDTH(8), .MAX_WORDS(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .pc_enable         (pc_enable),
    .if_id_enable      (if_id_enable),
    .core_reset        (core_reset),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .word_count        (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard, last one cycle, and stall the stream.
  always @(negedge clk) begin
    if (reset && mem_write_enable) begin
      check("strobe_single_cycle", {31'd0, prev_we}, 32'd0);
      check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_write_addr", {24'd0, mem_write_address}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", {24'd0, mem_write_address}, {24'd0, e.addr});
        check("write_data", mem_write_data, e.data);
      end
    end
    prev_we = reset && mem_write_enable;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready;
      step();
    end
    byte_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Sends one word MSB first; gap idle cycles are inserted after the second byte.
  task automatic send_word(input logic [31:0] w, input logic [7:0] addr, input int gap);
    wr_t e;
    e.addr = addr;
    e.data = w;
    sb.push_back(e);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    for (int g = 0; g < gap; g++) begin
      check("ready_during_gap", {31'd0, byte_ready}, 32'd1);
      step();
    end
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    check("strobe_after_4th_byte", {31'd0, mem_write_enable}, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10 && !done; i++) step();
    check("wait_done", {31'd0, done}, 32'd1);
  endtask

  task automatic check_released(input logic [7:0] count);
    check("done_flag", {31'd0, done}, 32'd1);
    check("word_count", {24'd0, word_count}, {24'd0, count});
    check("pc_enable_run", {31'd0, pc_enable}, 32'd1);
    check("if_id_enable_run", {31'd0, if_id_enable}, 32'd1);
    check("core_reset_run", {31'd0, core_reset}, 32'd0);
    check("busy_in_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_write_enable}, 32'd0);
    check({tag, "_addr"}, {24'd0, mem_write_address}, 32'd0);
    check({tag, "_data"}, mem_write_data, 32'd0);
    check({tag, "_pc_enable"}, {31'd0, pc_enable}, 32'd0);
    check({tag, "_if_id_enable"}, {31'd0, if_id_enable}, 32'd0);
    check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_word_count"}, {24'd0, word_count}, 32'd0);
  endtask

  initial begin
    // Reset for three cycles, then idle.
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("in_reset");
    reset = 1'b1;
    step();
    check_reset_state("idle");

    // Two-word program.
    pulse_start();
    check("header_ready", {31'd0, byte_ready}, 32'd1);
    check("header_busy", {31'd0, busy}, 32'd1);
    check("header_core_held", {31'd0, core_reset}, 32'd1);
    send_byte(8'h02);
    send_word(32'hE211_0000, 8'h00, 0);
    send_word(32'hE080_5183, 8'h04, 0);
    wait_done();
    check_released(8'd2);

    // Same program with a five-cycle gap inside word 0.
    pulse_start();
    check("restart_core_held", {31'd0, core_reset}, 32'd1);
    send_byte(8'h02);
    send_word(32'hE211_0000, 8'h00, 5);
    send_word(32'hE080_5183, 8'h04, 0);
    wait_done();
    check_released(8'd2);

    // Zero-length and oversize headers, then a one-word program.
    pulse_start();
    send_byte(8'h00);
    check("err_zero_flag", {31'd0, error}, 32'd1);
    check("err_zero_ready", {31'd0, byte_ready}, 32'd0);
    check("err_zero_busy", {31'd0, busy}, 32'd0);
    check("err_zero_core_held", {31'd0, core_reset}, 32'd1);
    pulse_start();
    check("err_cleared_on_start", {31'd0, error}, 32'd0);
    send_byte(8'h41);
    check("err_oversize_flag", {31'd0, error}, 32'd1);
    pulse_start();
    send_byte(8'h01);
    send_word(32'h0000_0000, 8'h00, 0);
    wait_done();
    check_released(8'd1);
    check("err_after_good_load", {31'd0, error}, 32'd0);

    // Reset in the middle of word 1, then reload a single word.
    pulse_start();
    send_byte(8'h02);
    send_word(32'h1122_3344, 8'h00, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b0;
    #1;
    check("midload_we", {31'd0, mem_write_enable}, 32'd0);
    check("midload_busy", {31'd0, busy}, 32'd0);
    check("midload_core_reset", {31'd0, core_reset}, 32'd1);
    check("midload_ready", {31'd0, byte_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    pulse_start();
    send_byte(8'h01);
    send_word(32'hAABB_CCDD, 8'h00, 0);
    wait_done();
    check_released(8'd1);

    // Full 64-word program, then restart from DONE.
    pulse_start();
    send_byte(8'h40);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      send_word({iv, 8'hC3, ~iv, 8'h3C}, {iv[5:0], 2'b00}, 0);
    end
    wait_done();
    check_released(8'd64);
    check("last_addr_held", {24'd0, mem_write_address}, 32'h0000_00FC);
    pulse_start();
    check("rehold_pc_enable", {31'd0, pc_enable}, 32'd0);
    check("rehold_if_id_enable", {31'd0, if_id_enable}, 32'd0);
    check("rehold_core_reset", {31'd0, core_reset}, 32'd1);
    check("rehold_done", {31'd0, done}, 32'd0);
    check("rehold_busy", {31'd0, busy}, 32'd1);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so a stuck handshake still ends with a summary line.
  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
